// File: rtl/mic_mavg_filter.sv
// Power-of-two boxcar moving average for signed mic samples, with valid/ready
// on both sides and full output backpressure (no skid buffer).
module mic_mavg_filter #(
  parameter int DW     = 16,
  parameter int LOG2_N = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic          din_rdy,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic          dout_rdy,
  output logic          primed
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = DW + LOG2_N;
  localparam logic [LOG2_N:0] FILL_FULL = (LOG2_N+1)'(N);

  logic [DW-1:0]        hist [N];
  logic [LOG2_N-1:0]    wptr;
  logic [LOG2_N:0]      fill;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sum_next;
  logic signed [SW-1:0] din_ext;
  logic signed [SW-1:0] old_ext;
  logic                 accept;

  assign din_rdy = ~clr & (~dout_vld | dout_rdy);
  assign accept  = din_vld & din_rdy;
  assign primed  = (fill == FILL_FULL);

  // The oldest sample sits at wptr, so it leaves the sum as the new one enters.
  assign din_ext  = {{LOG2_N{din[DW-1]}}, din};
  assign old_ext  = {{LOG2_N{hist[wptr][DW-1]}}, hist[wptr]};
  assign sum_next = sum + din_ext - old_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) hist[i] <= '0;
      wptr     <= '0;
      sum      <= '0;
      fill     <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < N; i++) hist[i] <= '0;
      wptr     <= '0;
      sum      <= '0;
      fill     <= '0;
      dout_vld <= 1'b0;
    end else if (accept) begin
      hist[wptr] <= din;
      wptr       <= wptr + LOG2_N'(1);
      sum        <= sum_next;
      // Taking the upper DW bits is an arithmetic shift right by LOG2_N.
      dout       <= sum_next[SW-1:LOG2_N];
      dout_vld   <= 1'b1;
      if (fill != FILL_FULL) fill <= fill + (LOG2_N+1)'(1);
    end else if (dout_rdy) begin
      dout_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mic_mavg_filter.sv
// Scoreboard bench for mic_mavg_filter: directed samples push hand-computed
// averages, a negedge monitor pops and compares on every output handshake.
module tb_mic_mavg_filter;

  localparam int DW     = 16;
  localparam int LOG2_N = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic [DW-1:0] din;
  logic          din_vld;
  logic          din_rdy;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_rdy;
  logic          primed;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  int ramp_exp[10]  = '{12, 25, 37, 50, 62, 75, 87, 100, 100, 100};
  int wrap_exp[8]   = '{0, 1, 2, 3, 4, 5, 6, 7};
  int pos_exp[8]    = '{4095, 8191, 12287, 16383, 20479, 24575, 28671, 32767};
  int neg_exp[8]    = '{24575, 16383, 8191, -1, -8193, -16385, -24577, -32768};
  int alt_exp[8]    = '{-24577, -24577, -16385, -16385, -8193, -8193, -1, -1};

  always #5 clk = ~clk;

  mic_mavg_filter #(.DW(DW), .LOG2_N(LOG2_N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .primed   (primed)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Inputs change only at posedge+1; din_rdy is judged at the following negedge.
  task automatic apply_stimulus(input int sample, input int expected, input bit push_exp);
    bit done = 1'b0;
    din     = DW'(sample);
    din_vld = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (c == 0) check_output("din_rdy", int'(din_rdy), 1);
      if (din_rdy) begin
        if (push_exp) exp_q.push_back(expected);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check_output("accept timeout", 0, 1);
  endtask

  task automatic clear_filter();
    din_vld = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  always @(negedge clk) begin
    int e;
    if (rst_n === 1'b1 && dout_vld === 1'b1 && dout_rdy === 1'b1 && clr === 1'b0) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected dout", int'($signed(dout)), 99999);
      end else begin
        e = exp_q.pop_front();
        check_output("dout", int'($signed(dout)), e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    din      = '0;
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    #1;
    check_output("reset dout_vld", int'(dout_vld), 0);
    check_output("reset dout", int'(dout), 0);
    check_output("reset primed", int'(primed), 0);
    check_output("reset din_rdy", int'(din_rdy), 1);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Constant 100 ramp; primed rises with the 8th accepted sample.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(100, ramp_exp[i], 1'b1);
      if (i == 6) check_output("primed after 7", int'(primed), 0);
      if (i == 7) check_output("primed after 8", int'(primed), 1);
    end

    clear_filter();
    for (int i = 0; i < 8; i++) apply_stimulus(-1, -1, 1'b1);
    for (int i = 0; i < 8; i++) apply_stimulus(7, wrap_exp[i], 1'b1);

    clear_filter();
    for (int i = 0; i < 8; i++) apply_stimulus(32767, pos_exp[i], 1'b1);
    for (int i = 0; i < 8; i++) apply_stimulus(-32768, neg_exp[i], 1'b1);
    for (int i = 0; i < 8; i++)
      apply_stimulus((i % 2 == 0) ? 32767 : -32768, alt_exp[i], 1'b1);

    // Backpressure: the first output stalls while a second sample waits.
    clear_filter();
    dout_rdy = 1'b0;
    apply_stimulus(100, 12, 1'b1);
    din     = DW'(200);
    din_vld = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_output("bp din_rdy", int'(din_rdy), 0);
      check_output("bp dout_vld", int'(dout_vld), 1);
      check_output("bp dout", int'($signed(dout)), 12);
    end
    @(posedge clk);
    #1;
    dout_rdy = 1'b1;
    apply_stimulus(200, 37, 1'b1);
    apply_stimulus(300, 75, 1'b1);
    apply_stimulus(400, 125, 1'b1);

    // Clear with an undelivered output; a sample offered during clr is ignored.
    clear_filter();
    for (int i = 0; i < 4; i++) apply_stimulus(100, ramp_exp[i], 1'b1);
    apply_stimulus(100, 62, 1'b0);
    dout_rdy = 1'b0;
    din_vld  = 1'b0;
    @(negedge clk);
    check_output("pend dout_vld", int'(dout_vld), 1);
    check_output("pend dout", int'($signed(dout)), 62);
    @(posedge clk);
    #1;
    clr     = 1'b1;
    din     = DW'(500);
    din_vld = 1'b1;
    @(negedge clk);
    check_output("clr din_rdy", int'(din_rdy), 0);
    @(posedge clk);
    #1;
    clr     = 1'b0;
    din_vld = 1'b0;
    @(negedge clk);
    check_output("clr dout_vld", int'(dout_vld), 0);
    check_output("clr primed", int'(primed), 0);
    check_output("clr dout hold", int'($signed(dout)), 62);
    @(posedge clk);
    #1;
    dout_rdy = 1'b1;
    apply_stimulus(80, 10, 1'b1);

    // Asynchronous reset between edges with a held output and primed window.
    clear_filter();
    for (int i = 0; i < 7; i++) apply_stimulus(100, ramp_exp[i], 1'b1);
    apply_stimulus(100, 100, 1'b0);
    dout_rdy = 1'b0;
    din_vld  = 1'b0;
    check_output("pre-reset primed", int'(primed), 1);
    #1 rst_n = 1'b0;
    #1;
    check_output("async dout_vld", int'(dout_vld), 0);
    check_output("async primed", int'(primed), 0);
    check_output("async dout", int'(dout), 0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    dout_rdy = 1'b1;
    apply_stimulus(16, 2, 1'b1);

    din_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("scoreboard drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
